// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Fetch stage between the program counter and the decoder. Issues the current
// PC to instruction memory (req/gnt/rvalid), buffers returned words in a small
// FIFO and presents them, with their fetch address, to the decoder through a
// valid/ready handshake. Drives the PC advance strobe.
//
// Parameters:
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
//   NOP_INSTR   word emitted with a misaligned-fetch fault entry
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   pc_in        in   current PC
//   flush        in   redirect this cycle; discards buffered/in-flight fetches
//   pc_enable    out  PC advance strobe (grant or redirect), combinational
//   imem_req     out  fetch request, combinational
//   imem_addr    out  word-aligned fetch address, combinational
//   imem_gnt     in   request accepted
//   imem_rvalid  in   response valid
//   imem_rdata   in   response word
//   instr_valid  out  buffer head valid (registered)
//   instr_out    out  head instruction (registered)
//   instr_pc     out  head fetch address (registered)
//   instr_fault  out  head is a misaligned-fetch fault (registered)
//   instr_ready  in   decoder accepts head
//
// Build option: define IF_MISALIGN_CHECK_EN to turn a misaligned pc_in into a
// fault entry plus a HALT stall; otherwise pc_in[1:0] is ignored and
// instr_fault is tied to 0.
// ----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        flush,
   output logic        pc_enable,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_fault,
   input  logic        instr_ready
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
`ifdef IF_MISALIGN_CHECK_EN
      ,
      HALT = 2'd3
`endif
   } state_t;

   state_t             state;
   logic               outstanding;
   logic               drop;
   logic [31:0]        pend_pc;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;

   logic [31:0]        mem_instr [FIFO_DEPTH];
   logic [31:0]        mem_pc    [FIFO_DEPTH];
`ifdef IF_MISALIGN_CHECK_EN
   logic               mem_fault [FIFO_DEPTH];
   logic               push_fault;
   logic               fault_q;
`endif

   logic               misalign;
   logic               can_issue;
   logic               fetch;
   logic               fault_push;
   logic               grant;
   logic               resp;
   logic               push;
   logic               pop;
   logic [31:0]        push_instr;
   logic [31:0]        push_pc;
   logic [CNT_W-1:0]   cnt_after_pop;
   logic [CNT_W-1:0]   cnt_next;
   logic [PTR_W-1:0]   rd_next;
   logic               bypass;

   // Issue decision, memory request and FIFO next-state bookkeeping
   always_comb begin
      misalign = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      misalign = (pc_in[1:0] != 2'b00);
`endif
      // count still includes an entry popped this cycle: conservative on purpose
      can_issue  = ((state == REQ) || ((state == WAIT) && imem_rvalid && !drop))
                   && !flush
                   && ((SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH));
      fetch      = can_issue && !misalign;
      // a misaligned PC is only turned into a fault from REQ, so it never
      // coincides with a response push
      fault_push = can_issue && misalign && (state == REQ);

      imem_req   = fetch;
      imem_addr  = fetch ? {pc_in[31:2], 2'b00} : 32'h0;
      grant      = fetch && imem_gnt;
      pc_enable  = grant || flush;

      resp       = (state == WAIT) && imem_rvalid;
      push       = !flush && ((resp && !drop) || fault_push);
      push_instr = fault_push ? NOP_INSTR : imem_rdata;
      push_pc    = fault_push ? pc_in : pend_pc;
`ifdef IF_MISALIGN_CHECK_EN
      push_fault = fault_push;
`endif
      pop        = instr_valid && instr_ready && !flush;

      cnt_after_pop = count - CNT_W'(pop);
      cnt_next      = flush ? '0 : (cnt_after_pop + CNT_W'(push));
      rd_next       = rd_ptr + PTR_W'(pop);
      // pushed word becomes the head directly when nothing else remains
      bypass        = push && (cnt_after_pop == '0);
   end

   // Buffer storage (no reset needed; validity tracked by count)
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= push_instr;
         mem_pc[wr_ptr]    <= push_pc;
`ifdef IF_MISALIGN_CHECK_EN
         mem_fault[wr_ptr] <= push_fault;
`endif
      end
   end

   // FSM, fetch tracking, FIFO pointers and registered head outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         pend_pc     <= 32'h0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         instr_valid <= 1'b0;
         instr_out   <= 32'h0;
         instr_pc    <= 32'h0;
`ifdef IF_MISALIGN_CHECK_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         count <= cnt_next;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            rd_ptr <= rd_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         end

         // head registers hold their last values while the buffer is empty
         instr_valid <= (cnt_next != '0);
         if (cnt_next != '0) begin
            if (bypass) begin
               instr_out <= push_instr;
               instr_pc  <= push_pc;
`ifdef IF_MISALIGN_CHECK_EN
               fault_q   <= push_fault;
`endif
            end else begin
               instr_out <= mem_instr[rd_next];
               instr_pc  <= mem_pc[rd_next];
`ifdef IF_MISALIGN_CHECK_EN
               fault_q   <= mem_fault[rd_next];
`endif
            end
         end

         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (grant) begin
                  pend_pc     <= imem_addr;
                  outstanding <= 1'b1;
                  state       <= WAIT;
               end
`ifdef IF_MISALIGN_CHECK_EN
               else if (fault_push) begin
                  state <= HALT;
               end
`endif
            end
            WAIT: begin
               if (flush) begin
                  // response in the flush cycle retires the fetch; otherwise
                  // wait for it with the drop flag set
                  if (resp) begin
                     outstanding <= 1'b0;
                     drop        <= 1'b0;
                     state       <= REQ;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (resp) begin
                  drop <= 1'b0;
                  if (grant) begin
                     pend_pc <= imem_addr;
                  end else begin
                     outstanding <= 1'b0;
                     state       <= REQ;
                  end
               end
            end
`ifdef IF_MISALIGN_CHECK_EN
            HALT: begin
               if (flush) state <= REQ;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   assign instr_fault = fault_q;
`else
   assign instr_fault = 1'b0;
`endif

endmodule
